// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin arbiter sharing one combinational ALU among NREQ
// requesters, with a registered issue stage and a registered response stage.
module alu_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [6*NREQ-1:0]    req_opcode,
  input  logic [32*NREQ-1:0]   req_a,
  input  logic [32*NREQ-1:0]   req_b,
  output logic [NREQ-1:0]      req_ready,
  output logic [31:0]          alu_r2,
  output logic [31:0]          alu_r3,
  output logic [5:0]           alu_opcode,
  input  logic [31:0]          alu_out,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [31:0]          rsp_data,
  input  logic                 rsp_ready
);

  localparam int unsigned OPW = 6;
  localparam int unsigned DW  = 32;

  logic              s1_valid;
  logic [IDW-1:0]    s1_id;
  logic [OPW-1:0]    s1_op;
  logic [DW-1:0]     s1_a;
  logic [DW-1:0]     s1_b;
  logic [IDW-1:0]    last_grant;

  logic              rsp_free;
  logic              s1_adv;
  logic              accept_en;
  logic              accept;

  logic [IDW-1:0]    start_idx;
  logic [NREQ-1:0]   valid_rot;
  logic [NREQ-1:0]   pick_rot;
  logic [NREQ-1:0]   grant_c;
  logic [IDW-1:0]    grant_idx;

  logic [OPW-1:0]    op_arr [NREQ];
  logic [DW-1:0]     a_arr  [NREQ];
  logic [DW-1:0]     b_arr  [NREQ];

  // Unpack the per-requester fields into arrays indexed by requester ID
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign op_arr[g] = req_opcode[OPW*g +: OPW];
    assign a_arr[g]  = req_a[DW*g +: DW];
    assign b_arr[g]  = req_b[DW*g +: DW];
  end

  // Pipeline flow control
  assign rsp_free  = !rsp_valid || rsp_ready;
  assign s1_adv    = s1_valid && rsp_free;
  assign accept_en = !s1_valid || rsp_free;

  // Round-robin pick: rotate so the search start is bit 0, isolate the lowest
  // set bit, then rotate the one-hot result back into requester order
  always_comb begin
    start_idx = (last_grant == IDW'(NREQ - 1)) ? '0 : last_grant + IDW'(1);
    valid_rot = NREQ'({req_valid, req_valid} >> start_idx);
    pick_rot  = valid_rot & (~valid_rot + NREQ'(1));
    grant_c   = NREQ'(({pick_rot, pick_rot} << start_idx) >> NREQ);
  end

  // One-hot grant to requester index
  always_comb begin
    grant_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[IDW'(i)]) grant_idx = IDW'(i);
    end
  end

  // Grant is suppressed while held in reset or when the issue stage cannot take a request
  assign req_ready = (rst_n && accept_en) ? grant_c : '0;
  assign accept    = |req_ready;

  // Operands to the shared ALU, forced to zero when the issue stage is empty
  assign alu_opcode = s1_valid ? s1_op : '0;
  assign alu_r2     = s1_valid ? s1_a  : '0;
  assign alu_r3     = s1_valid ? s1_b  : '0;

  // Issue stage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_id    <= '0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (accept) begin
      s1_valid <= 1'b1;
      s1_id    <= grant_idx;
      s1_op    <= op_arr[grant_idx];
      s1_a     <= a_arr[grant_idx];
      s1_b     <= b_arr[grant_idx];
    end else if (s1_adv) begin
      s1_valid <= 1'b0;
    end
  end

  // Response stage register; payload holds while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else if (s1_adv) begin
      rsp_valid <= 1'b1;
      rsp_id    <= s1_id;
      rsp_data  <= alu_out;
    end else if (rsp_valid && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  // Round-robin pointer; reset value gives requester 0 first priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
    end else if (accept) begin
      last_grant <= grant_idx;
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: self-checking bench for alu_arbiter with a bench-side ALU
// and a transaction-level reference model.
module tb_alu_arbiter;

  localparam int unsigned NREQ = 4;
  localparam int unsigned IDW  = 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [23:0]  req_opcode;
  logic [127:0] req_a;
  logic [127:0] req_b;
  logic [3:0]   req_ready;
  logic [31:0]  alu_r2;
  logic [31:0]  alu_r3;
  logic [5:0]   alu_opcode;
  logic [31:0]  alu_out;
  logic         rsp_valid;
  logic [1:0]   rsp_id;
  logic [31:0]  rsp_data;
  logic         rsp_ready;

  alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_opcode (req_opcode),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_ready  (req_ready),
    .alu_r2     (alu_r2),
    .alu_r3     (alu_r3),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .rsp_valid  (rsp_valid),
    .rsp_id     (rsp_id),
    .rsp_data   (rsp_data),
    .rsp_ready  (rsp_ready)
  );

  always #5 clk = ~clk;

  // Bench-side ALU; unknown opcodes fold all six opcode bits into the result
  function automatic logic [31:0] alu_f(input logic [5:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      6'd0:    return a & b;
      6'd1:    return a | b;
      6'd3:    return a + b;
      6'd4:    return a - b;
      6'd6:    return a ^ b;
      6'd7:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return a ^ b ^ {26'd0, op};
    endcase
  endfunction

  always_comb alu_out = alu_f(alu_opcode, alu_r2, alu_r3);

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    int          acc;
  } ent_t;

  typedef struct {
    int          id;
    logic [5:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lastg   = 3;
  ent_t q[$];
  int glog[$];

  logic [3:0]  pv;
  logic [5:0]  pop [4];
  logic [31:0] pa  [4];
  logic [31:0] pb  [4];
  logic        rrdy;

  int          acc_cyc_last;
  int          rsp_cyc_last;
  int          rsp_id_last;
  logic [31:0] rsp_data_last;
  int          nrsp = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic drive_inputs();
    req_valid  = pv;
    req_opcode = {pop[3], pop[2], pop[1], pop[0]};
    req_a      = {pa[3], pa[2], pa[1], pa[0]};
    req_b      = {pb[3], pb[2], pb[1], pb[0]};
    rsp_ready  = rrdy;
  endtask

  task automatic model_reset();
    q.delete();
    lastg = 3;
  endtask

  // One clock cycle: drive, check against the model, advance the model, clock
  task automatic step();
    logic [3:0] eg;
    int cnt;
    bit aen;
    bit exp_rv;
    bit found;
    int gi;
    int j;
    int s1n;
    ent_t e;
    drive_inputs();
    #1;
    cnt = q.size();
    // At most two transactions in flight; with both stages full only a response handoff frees space
    aen = (cnt < 2) || rrdy;
    found = 0;
    gi = 0;
    for (int k = 1; k <= 4; k++) begin
      j = (lastg + k) % 4;
      if (!found && pv[j]) begin
        found = 1;
        gi = j;
      end
    end
    eg = 4'b0;
    if (aen && found) eg[gi] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(eg));
    // Oldest transaction is in the response stage once it is two or more cycles old
    exp_rv = (cnt > 0) && (cyc - q[0].acc >= 2);
    chk("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    if (exp_rv) begin
      chk("rsp_id", 64'(rsp_id), 64'(q[0].id));
      chk("rsp_data", 64'(rsp_data), 64'(q[0].res));
    end
    s1n = exp_rv ? cnt - 1 : cnt;
    if (s1n == 0) begin
      chk("alu_idle", 64'(|{alu_opcode, alu_r2, alu_r3}), 64'(0));
    end else begin
      e = q[exp_rv ? 1 : 0];
      chk("alu_opcode", 64'(alu_opcode), 64'(e.op));
      chk("alu_r2", 64'(alu_r2), 64'(e.a));
      chk("alu_r3", 64'(alu_r3), 64'(e.b));
    end
    if (rsp_valid && rrdy) begin
      rsp_data_last = rsp_data;
      rsp_id_last   = int'(rsp_id);
      rsp_cyc_last  = cyc;
      nrsp++;
    end
    if (exp_rv && rrdy) void'(q.pop_front());
    if (eg != 4'b0) begin
      e.id  = gi;
      e.op  = pop[gi];
      e.a   = pa[gi];
      e.b   = pb[gi];
      e.res = alu_f(pop[gi], pa[gi], pb[gi]);
      e.acc = cyc;
      q.push_back(e);
      lastg = gi;
      pv[gi] = 1'b0;
      glog.push_back(gi);
      acc_cyc_last = cyc;
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [5:0] op, input logic [31:0] a,
                         input logic [31:0] b);
    pv[i]  = 1'b1;
    pop[i] = op;
    pa[i]  = a;
    pb[i]  = b;
  endtask

  task automatic hold_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  vec_t tbl[7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int seq2 [6];
    logic [31:0] r;

    tbl[0] = '{id: 0, op: 6'b000011, a: 32'd5,        b: 32'd7,        exp: 32'd12};
    tbl[1] = '{id: 2, op: 6'b000111, a: 32'hFFFFFFFF, b: 32'd1,        exp: 32'd1};
    tbl[2] = '{id: 2, op: 6'b000110, a: 32'hFFFFFFFF, b: 32'd1,        exp: 32'hFFFFFFFE};
    tbl[3] = '{id: 1, op: 6'd4,      a: 32'd10,       b: 32'd3,        exp: 32'd7};
    tbl[4] = '{id: 3, op: 6'h3F,     a: 32'd0,        b: 32'd0,        exp: 32'h3F};
    tbl[5] = '{id: 0, op: 6'd0,      a: 32'h0000F0F0, b: 32'h0000FF00, exp: 32'h0000F000};
    tbl[6] = '{id: 1, op: 6'd7,      a: 32'd1,        b: 32'hFFFFFFFF, exp: 32'd0};

    for (int i = 0; i < 4; i++) set_req(i, 6'(i + 1), 32'(i * 3), 32'(i + 9));
    rrdy  = 1'b1;
    rst_n = 1'b0;
    drive_inputs();
    #1;
    chk("reset_req_ready", 64'(req_ready), 64'(0));
    chk("reset_rsp", 64'({rsp_valid, rsp_id, rsp_data}), 64'(0));
    chk("reset_alu", 64'(|{alu_opcode, alu_r2, alu_r3}), 64'(0));
    pv = 4'b0;
    hold_reset();

    // Directed single-request vectors: result, owner and two-cycle latency
    for (int v = 0; v < 7; v++) begin
      n0 = nrsp;
      pv = 4'b0;
      set_req(tbl[v].id, tbl[v].op, tbl[v].a, tbl[v].b);
      step();
      for (int w = 0; w < 10 && nrsp == n0; w++) step();
      chk("tbl_rsp_seen", 64'(nrsp - n0), 64'(1));
      chk("tbl_data", 64'(rsp_data_last), 64'(tbl[v].exp));
      chk("tbl_id", 64'(rsp_id_last), 64'(tbl[v].id));
      chk("tbl_latency", 64'(rsp_cyc_last - acc_cyc_last), 64'(2));
    end

    // All four requesters hold valid: grants follow 0,1,2,3,0,1
    rst_n = 1'b0;
    #1;
    hold_reset();
    glog.delete();
    seq2 = '{0, 1, 2, 3, 0, 1};
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 4; i++) set_req(i, 6'd3, 32'(100 * i + s), 32'(s));
      step();
    end
    chk("s2_grant_count", 64'(glog.size()), 64'(6));
    for (int s = 0; s < 6 && s < glog.size(); s++) chk("s2_grant_order", 64'(glog[s]), 64'(seq2[s]));
    pv = 4'b0;
    repeat (3) step();

    // Consumer stalls: at most two accepted, then drain in order
    rrdy = 1'b0;
    glog.delete();
    for (int s = 0; s < 6; s++) begin
      for (int i = 0; i < 4; i++) if (!pv[i]) set_req(i, 6'd6, $urandom(), $urandom());
      step();
    end
    chk("s3_accepted", 64'(glog.size()), 64'(2));
    n0 = nrsp;
    rrdy = 1'b1;
    pv = 4'b0;
    repeat (4) step();
    chk("s3_drained", 64'(nrsp - n0), 64'(2));
    chk("s3_model_empty", 64'(q.size()), 64'(0));

    // Only requesters 1 and 3 active: alternate without dead cycles
    rst_n = 1'b0;
    #1;
    hold_reset();
    glog.delete();
    for (int s = 0; s < 6; s++) begin
      set_req(1, 6'd3, 32'(s), 32'd1);
      set_req(3, 6'd4, 32'(s), 32'd1);
      step();
    end
    chk("s5_grant_count", 64'(glog.size()), 64'(6));
    for (int s = 0; s < 6 && s < glog.size(); s++) chk("s5_grant_alt", 64'(glog[s]), 64'((s % 2 == 0) ? 1 : 3));
    pv = 4'b0;
    repeat (3) step();

    // Randomized traffic against the model
    for (int s = 0; s < 500; s++) begin
      for (int i = 0; i < 4; i++) begin
        if (!pv[i] && $urandom_range(0, 99) < 40) begin
          r = $urandom();
          set_req(i, r[5:0], $urandom(), (r[6]) ? 32'($urandom_range(0, 15)) : $urandom());
        end
      end
      rrdy = ($urandom_range(0, 99) < 70);
      step();
    end
    rrdy = 1'b1;
    pv = 4'b0;
    repeat (5) step();
    chk("rand_model_empty", 64'(q.size()), 64'(0));

    // Reset pulse with both stages full, then 0 beats 3 on a tie
    rrdy = 1'b0;
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 4; i++) if (!pv[i]) set_req(i, 6'd1, $urandom(), $urandom());
      step();
    end
    chk("s6_full", 64'(q.size()), 64'(2));
    pv = 4'b1001;
    drive_inputs();
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("s6_req_ready", 64'(req_ready), 64'(0));
    chk("s6_alu_idle", 64'(|{alu_opcode, alu_r2, alu_r3}), 64'(0));
    hold_reset();
    rrdy = 1'b1;
    glog.delete();
    pv = 4'b0;
    set_req(0, 6'd3, 32'd20, 32'd22);
    set_req(3, 6'd3, 32'd30, 32'd33);
    step();
    chk("s6_grant_count", 64'(glog.size()), 64'(1));
    if (glog.size() > 0) chk("s6_first_grant", 64'(glog[0]), 64'(0));
    repeat (4) step();
    chk("s6_model_empty", 64'(q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of requesters sharing the ALU, legal range 2..8.
REQ-002 Parameter IDW, default 2: requester-ID width, SHALL equal ceil(log2(NREQ)).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 clk  in  1  rising-edge clock for all state.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req_valid  in  NREQ  per-requester request strobe.
REQ-007 req_opcode  in  6*NREQ  packed opcodes; requester i uses bits [6i+5:6i].
REQ-008 req_a  in  32*NREQ  packed first operands (R2); requester i uses bits [32i+31:32i].
REQ-009 req_b  in  32*NREQ  packed second operands (R3), same packing as req_a.
REQ-010 req_ready  out  NREQ  one-hot grant; request i is accepted on a cycle with req_valid[i] and req_ready[i] both high.
REQ-011 alu_r2, alu_r3  out  32 each  operands to the shared ALU.
REQ-012 alu_opcode  out  6  opcode to the shared ALU.
REQ-013 alu_out  in  32  combinational ALU result.
REQ-014 rsp_valid  out  1  response available.
REQ-015 rsp_id  out  IDW  index of the requester owning the response.
REQ-016 rsp_data  out  32  result.
REQ-017 rsp_ready  in  1  consumer accepts the response.

Function
REQ-018 Pipeline SHALL have two register stages: issue (s1_valid, s1_id, s1_op, s1_a, s1_b) and response (rsp_valid, rsp_id, rsp_data).
REQ-019 alu_r2/alu_r3/alu_opcode SHALL be driven from s1_a/s1_b/s1_op when s1_valid=1 and SHALL be all-zero otherwise.
REQ-020 rsp_free = !rsp_valid || rsp_ready; s1_adv = s1_valid && rsp_free; accept_en = !s1_valid || rsp_free.
REQ-021 On s1_adv, the response register SHALL load rsp_data=alu_out and rsp_id=s1_id, and set rsp_valid=1.
REQ-022 If rsp_valid && rsp_ready && !s1_adv, rsp_valid SHALL clear; rsp_data and rsp_id SHALL hold while rsp_valid=1 && !rsp_ready.
REQ-023 req_ready SHALL be all-zero when accept_en=0 or no req_valid bit is set; otherwise exactly one bit SHALL be set.
REQ-024 Grant SHALL be round-robin: the search starts at (last_grant+1) mod NREQ, and the first index with req_valid set wins.
REQ-025 last_grant SHALL update only on a cycle with an accepted request.
REQ-026 On acceptance, the issue stage SHALL load the granted requester's opcode and operands, set s1_id to its index, and set s1_valid=1.
REQ-027 If there is no acceptance and s1_adv=1, s1_valid SHALL clear.
REQ-028 Latency: an accepted request in cycle N SHALL appear with rsp_valid=1 in cycle N+2 if rsp_free held in cycle N+1.
REQ-029 With rsp_ready held high, throughput SHALL be one request per cycle.
REQ-030 Simultaneous rsp handoff and new acceptance in one cycle SHALL lose no data.
REQ-031 The block SHALL NOT interpret opcodes; all six bits SHALL pass unchanged to the ALU.
REQ-032 Requests that are not granted SHALL wait without loss; requesters keep their inputs stable until granted.

Reset
REQ-033 While rst_n=0, the block SHALL set s1_valid=0, rsp_valid=0, rsp_id=0, rsp_data=0, req_ready=0, alu_* outputs=0, and last_grant=NREQ-1, so requester 0 has first priority.
REQ-034 Reset asserted mid-operation SHALL discard in-flight issue and response contents immediately, without a clock edge.
REQ-035 On release of rst_n, the first grant SHALL be possible on the first rising edge of clk.

Verification
REQ-036 Scenario 1: req0 issues opcode 6'b000011, a=5, b=7, with rsp_ready=1 -> rsp_valid=1, rsp_id=0, rsp_data=12 exactly two cycles after acceptance.
REQ-037 Scenario 2: all four requesters hold valid continuously with rsp_ready=1 -> grant order is 0,1,2,3,0,1 and one response is produced per cycle, in the same order.
REQ-038 Scenario 3: rsp_ready=0 while requests are pending -> at most two requests are accepted, req_ready goes 0, and rsp_data stays stable; after rsp_ready rises, responses drain in order and none are lost.
REQ-039 Scenario 4: req2 issues opcode 6'b000111, a=32'hFFFFFFFF, b=1 -> rsp_data=1 (signed less-than); the same request with opcode 6'b000110 -> rsp_data=32'hFFFFFFFE.
REQ-040 Scenario 5: only req1 and req3 toggle valid -> each is granted alternately, and the idle indices are skipped without dead cycles.
REQ-041 Scenario 6: rst_n is pulsed low while the issue and response stages are full -> rsp_valid=0 and req_ready=0 immediately; after release, requester 0 wins a tie against requester 3.
